// File: rtl/async_slave.sv
// Responder side of the 4-bit asynchronous req/rw/data_bus handshake.
// Writes land in a local RX FIFO; reads are served from a locally loaded TX holding register.
module async_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int AW          = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          rw,
    inout  wire  [3:0]    data_bus,
    output logic          ack,
    output logic [3:0]    rx_data,
    output logic          rx_empty,
    output logic          rx_full,
    output logic [AW:0]   rx_count,
    input  logic          rx_pop,
    input  logic [3:0]    tx_data,
    input  logic          tx_load,
    output logic          tx_valid,
    output logic          wr_ovf,
    output logic          rd_unf,
    input  logic          err_clr
);

    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] rw_sync;
    logic [3:0]             bus_sync [SYNC_STAGES];

    logic       req_s;
    logic       rw_s;
    logic [3:0] bus_s;
    logic       req_d;
    logic       req_rise;

    logic [3:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [3:0]  tx_reg;

    logic write_ev;
    logic read_ev;
    logic do_pop;
    logic do_push;
    logic ovf_set;
    logic unf_set;

    // Data travels through the same number of stages as req so it stays aligned with the strobe.
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync <= '0;
            rw_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                bus_sync[i] <= 4'h0;
            end
            req_d    <= 1'b0;
        end else begin
            req_sync    <= {req_sync[SYNC_STAGES-2:0], req};
            rw_sync     <= {rw_sync[SYNC_STAGES-2:0], rw};
            bus_sync[0] <= data_bus;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bus_sync[i] <= bus_sync[i-1];
            end
            req_d       <= req_s;
        end
    end

    assign req_s    = req_sync[SYNC_STAGES-1];
    assign rw_s     = rw_sync[SYNC_STAGES-1];
    assign bus_s    = bus_sync[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_d;

    assign write_ev = req_rise & ~rw_s;
    assign read_ev  = req_rise & rw_s;

    // A pop on a full FIFO frees the slot the coincident write needs.
    assign do_pop   = rx_pop & ~rx_empty;
    assign do_push  = write_ev & (~rx_full | do_pop);
    assign ovf_set  = write_ev & rx_full & ~rx_pop;
    assign unf_set  = read_ev & ~tx_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack <= 1'b0;
        end else begin
            ack <= req_rise;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; contents are only visible once a pointer covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= bus_s;
        end
    end

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_count = wr_ptr - rd_ptr;
    assign rx_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_reg   <= 4'h0;
            tx_valid <= 1'b0;
        end else if (tx_load) begin
            tx_reg   <= tx_data;
            tx_valid <= 1'b1;
        end else if (read_ev) begin
            tx_valid <= 1'b0;
        end
    end

    // Sticky error flags: a new event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ovf <= 1'b0;
            rd_unf <= 1'b0;
        end else begin
            if (ovf_set) begin
                wr_ovf <= 1'b1;
            end else if (err_clr) begin
                wr_ovf <= 1'b0;
            end
            if (unf_set) begin
                rd_unf <= 1'b1;
            end else if (err_clr) begin
                rd_unf <= 1'b0;
            end
        end
    end

    // The bus stays driven for the whole synchronised read window, including after the consume.
    assign data_bus = rw_s ? tx_reg : 4'bz;

endmodule
